// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared definitions for the IF/ID instruction queue.
//   ZeroWord        - all-zero word, also the bubble encoding of pc/inst/excepttype
//   StallIfIdIdx    - stall-bus bit driving stall_up (IF/ID boundary)
//   StallIdIdx      - stall-bus bit driving stall_down (decode stage)
//   out_action_e    - what the decode-facing output stage does on a given edge
//   pick_action()   - priority decode of flush / stall / FIFO state into an action
package if_id_queue_pkg;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam int          StallBusW    = 6;
  localparam int          StallIfIdIdx = 1;  // stall_up   = stall[StallIfIdIdx]
  localparam int          StallIdIdx   = 2;  // stall_down = stall[StallIdIdx]

  typedef enum logic [2:0] {
    OUT_FLUSH     = 3'd0,
    OUT_BUBBLE    = 3'd1,
    OUT_LOAD_HEAD = 3'd2,
    OUT_BYPASS    = 3'd3,
    OUT_HOLD      = 3'd4
  } out_action_e;

  // Flush beats everything; a stall at IF/ID with decode free injects a
  // bubble; with both stalled the output simply holds.
  function automatic out_action_e pick_action(input logic flush,
                                              input logic stall_up,
                                              input logic stall_down,
                                              input logic fifo_empty,
                                              input logic in_valid);
    out_action_e act;
    if (flush)
      act = OUT_FLUSH;
    else if (stall_up && !stall_down)
      act = OUT_BUBBLE;
    else if (!stall_up) begin
      if (!fifo_empty)
        act = OUT_LOAD_HEAD;
      else if (in_valid)
        act = OUT_BYPASS;
      else
        act = OUT_BUBBLE;
    end else
      act = OUT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/if_id_queue_ring.sv
// ifid_ring: DEPTH-entry circular buffer of packed {pc, inst, excepttype}.
//   clk, rst (async, active-low)
//   clear        - synchronous empty (flush)
//   push, wdata  - write an entry at the tail
//   pop, rdata   - rdata is always the head; pop advances past it
//   full, empty, count
// Push when full is honoured only together with a pop; pop when empty is ignored.
module ifid_ring #(
  parameter int EW    = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [EW-1:0]              wdata,
  input  logic                       pop,
  output logic [EW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign pop_ok  = pop && !empty && !clear;
  assign push_ok = push && (!full || pop_ok) && !clear;

  // Head is read combinationally; the caller's output stage is the register.
  // On full+pop+push the write lands on the head slot, but the old head is
  // still what rdata shows this cycle.
  assign rdata = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID boundary with a DEPTH-entry instruction queue and a
// registered decode-facing output stage.
//   clk, rst (async, active-low), flush, stall_up, stall_down
//   fetch side : if_valid, if_ready, if_pc, if_inst, icache_excepttype
//   decode side: id_valid, id_pc, id_inst, id_excepttype
//   optional (IFID_PERF_EN): perf_bubble_cnt, perf_occupancy
// An instruction with pc==0 carries inst 0 whichever path it takes.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_up,
  input  logic                   stall_down,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [PC_W-1:0]        if_pc,
  input  logic [INST_W-1:0]      if_inst,
  input  logic [EXC_W-1:0]       icache_excepttype,
  output logic                   id_valid,
  output logic [PC_W-1:0]        id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [EXC_W-1:0]       id_excepttype
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]            perf_bubble_cnt,
  output logic [$clog2(DEPTH):0] perf_occupancy
`endif
);

  localparam int EW = PC_W + INST_W + EXC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic              ring_push;
  logic              ring_pop;
  logic              ring_full;
  logic              ring_empty;
  logic [CW-1:0]     ring_count;
  logic [EW-1:0]     ring_rdata;
  logic [EW-1:0]     in_entry;
  logic [INST_W-1:0] in_inst_clean;
  logic              advance;
  logic              bypass;
  out_action_e       action;

  assign in_inst_clean = (if_pc == '0) ? '0 : if_inst;
  assign in_entry      = {if_pc, in_inst_clean, icache_excepttype};

  always_comb begin
    advance   = !flush && !stall_up;
    ring_pop  = advance && !ring_empty;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    if_ready  = !flush && (!ring_full || ring_pop);
    bypass    = advance && ring_empty && if_valid;
    ring_push = if_valid && if_ready && !bypass;
    action    = pick_action(flush, stall_up, stall_down, ring_empty, if_valid);
  end

  ifid_ring #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (ring_push),
    .wdata (in_entry),
    .pop   (ring_pop),
    .rdata (ring_rdata),
    .full  (ring_full),
    .empty (ring_empty),
    .count (ring_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_inst       <= '0;
      id_excepttype <= '0;
    end else begin
      case (action)
        OUT_LOAD_HEAD: begin
          id_valid                          <= 1'b1;
          {id_pc, id_inst, id_excepttype}   <= ring_rdata;
        end
        OUT_BYPASS: begin
          id_valid                          <= 1'b1;
          {id_pc, id_inst, id_excepttype}   <= in_entry;
        end
        OUT_HOLD: begin
          id_valid      <= id_valid;
          id_pc         <= id_pc;
          id_inst       <= id_inst;
          id_excepttype <= id_excepttype;
        end
        default: begin  // flush or bubble: all-zero encoding
          id_valid      <= 1'b0;
          id_pc         <= '0;
          id_inst       <= '0;
          id_excepttype <= '0;
        end
      endcase
    end
  end

`ifdef IFID_PERF_EN
  // Counts bubbles that cost decode a slot; flush bubbles are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_bubble_cnt <= '0;
    else if (action == OUT_BUBBLE && perf_bubble_cnt != 32'hFFFF_FFFF)
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end

  assign perf_occupancy = ring_count;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall_up;
  logic        stall_down;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] icache_excepttype;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_excepttype;
`ifdef IFID_PERF_EN
  logic [31:0] perf_bubble_cnt;
  logic [2:0]  perf_occupancy;
`endif

  int total = 0;
  int bad   = 0;
  entry_t sb[$];

  always #5 clk = ~clk;

  if_id_queue #(.PC_W(32), .INST_W(32), .EXC_W(32), .DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall_up          (stall_up),
    .stall_down        (stall_down),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .icache_excepttype (icache_excepttype),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_inst           (id_inst),
    .id_excepttype     (id_excepttype)
`ifdef IFID_PERF_EN
    ,
    .perf_bubble_cnt   (perf_bubble_cnt),
    .perf_occupancy    (perf_occupancy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] exc);
    if_valid          = v;
    if_pc             = pc;
    if_inst           = inst;
    icache_excepttype = exc;
  endtask

  task automatic set_stall(input logic up, input logic down);
    stall_up   = up;
    stall_down = down;
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] exc);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    e.exc  = exc;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    entry_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: observed=output with empty scoreboard expected=queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
      check({tag, "_pc"},    id_pc,             e.pc);
      check({tag, "_inst"},  id_inst,           e.inst);
      check({tag, "_exc"},   id_excepttype,     e.exc);
      $display("tx %s pc=%h inst=%h exc=%h", tag, id_pc, id_inst, id_excepttype);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_pc"},    id_pc,             32'd0);
    check({tag, "_inst"},  id_inst,           32'd0);
    check({tag, "_exc"},   id_excepttype,     32'd0);
    $display("tx %s bubble", tag);
  endtask

  task automatic check_count(input string tag, input logic [31:0] exp);
    check(tag, {29'd0, dut.u_ring.count_reg}, exp);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, if_ready}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b0;
    flush = 1'b0;
    set_stall(1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    check_bubble("reset");
    check_count("reset_count", 0);
    check_ready("reset_ready", 1'b1);

    // Bypass: empty queue, advancing
    drive(1'b1, 32'hBFC0_0000, 32'h2408_0001, 32'h0);
    check_ready("bypass_ready", 1'b1);
    expect_push(32'hBFC0_0000, 32'h2408_0001, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_pop("bypass");
    check_count("bypass_count", 0);

    // Fill under full hold; 5th instruction is refused until release
    set_stall(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * (k < 4 ? k : 4));
      drive(1'b1, pc, pc + 32'h1000, 32'h0);
      check_ready($sformatf("fill_ready%0d", k), k < 4);
      if (k < 4) expect_push(pc, pc + 32'h1000, 32'h0);
      step();
    end
    check_count("fill_count", 4);
    check("hold_pc", id_pc, 32'hBFC0_0000);
    set_stall(1'b0, 1'b0);
    drive(1'b1, 32'h110, 32'h1110, 32'h0);
    check_ready("full_pop_ready", 1'b1);
    expect_push(32'h110, 32'h1110, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_count("full_pop_count", 4);
    check_pop("drain0");
    for (int k = 1; k < 5; k++) begin
      step();
      check_pop($sformatf("drain%0d", k));
    end
    step();
    check_bubble("drain_empty");
    check_count("drain_count", 0);

    // Stall bubble with two entries queued
    set_stall(1'b1, 1'b1);
    drive(1'b1, 32'h200, 32'h2200, 32'h0);
    expect_push(32'h200, 32'h2200, 32'h0);
    step();
    drive(1'b1, 32'h204, 32'h2204, 32'h0);
    expect_push(32'h204, 32'h2204, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    set_stall(1'b1, 1'b0);
    step();
    check_bubble("stall_bubble");
    check_count("stall_bubble_count", 2);
    set_stall(1'b0, 1'b0);
    step();
    check_pop("after_bubble0");
    step();
    check_pop("after_bubble1");

    // Full queue then flush with a valid input
    drive(1'b1, 32'h2F0, 32'h22F0, 32'h0);
    expect_push(32'h2F0, 32'h22F0, 32'h0);
    step();
    check_pop("pre_flush");
    set_stall(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 32'h3300 + 32'(4 * k), 32'h0);
      step();
    end
    check_count("preflush_count", 4);
    flush = 1'b1;
    drive(1'b1, 32'h400, 32'h4400, 32'h0);
    check_ready("flush_ready", 1'b0);
    step();
    flush = 1'b0;
    set_stall(1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_bubble("flush");
    check_count("flush_count", 0);
    step();
    check_bubble("post_flush");

    // pc==0 zeroes inst (bypass and queued), excepttype passes through
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0);
    expect_push(32'h0, 32'h0, 32'h0);
    step();
    check_pop("pc0_bypass");
    set_stall(1'b1, 1'b1);
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0);
    expect_push(32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h500, 32'h3C1D_0000, 32'h0000_0004);
    expect_push(32'h500, 32'h3C1D_0000, 32'h0000_0004);
    step();
    set_stall(1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check_pop("pc0_queued");
    step();
    check_pop("exc_queued");

    // Asynchronous reset with three entries queued
    set_stall(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h600 + 32'(4 * k), 32'h6600 + 32'(4 * k), 32'h0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check_count("prereset_count", 3);
    check("prereset_hold_pc", id_pc, 32'h500);
    #2 rst = 1'b0;
    #1;
    check_bubble("async_reset");
    check_count("async_reset_count", 0);
    sb.delete();
    set_stall(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("post_reset_ready", {31'd0, if_ready}, 32'd1);
    check_count("post_reset_count", 0);
`ifdef IFID_PERF_EN
    check("perf_bubble_reset", perf_bubble_cnt, 32'd0);
`endif
    step();
    check_bubble("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
